// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock timekeeping block.
// Mode encodings, display blank code, BCD field limits, BCD step helper.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_BAD      = 2'd3
  } mode_t;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [7:0] HOUR_MAX  = 8'h23;
  localparam logic [7:0] MIN_MAX   = 8'h59;

  // Two-digit BCD +1 that wraps to 00 after max.
  function automatic logic [7:0] bcd_next(
    input logic [7:0] v,
    input logic [7:0] max
  );
    if (v == max)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/clock_time_controller_bcd_mod_counter.sv
// Two-digit BCD modulo counter (00..MAX) with clear and carry.
// Ports: clk, reset, clr, inc in; value[7:0], carry (inc at MAX) out.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] value,
  output logic       carry
);

  always_ff @(posedge clk) begin
    if (reset || clr)
      value <= 8'h00;
    else if (inc)
      value <= bcd_next(value, MAX);
  end

  assign carry = inc && (value == MAX);

endmodule

// File: rtl/clock_time_controller.sv
// Clock timekeeping: 1 Hz prescaler, HH:MM:SS BCD time, set-mode FSM.
// Ports: clk, reset, btn_mode, btn_inc in; bcd[15:0], colon_on, mode, tick_1hz out.
module clock_time_controller
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [15:0] bcd,
  output logic        colon_on,
  output logic [1:0]  mode,
  output logic        tick_1hz
);

  localparam int CW = $clog2(CLK_HZ);
  localparam logic [CW-1:0] TC   = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_HZ / 2);

  mode_t state, state_d;
  logic [CW-1:0] count, count_d;
  logic run, set_hour, set_min, exit_set, phase_hi;
  logic sec_inc, min_inc, hour_inc;
  logic sec_carry, min_carry, hour_carry_unused;
  logic [7:0] sec_v, min_v, hour_v;
  logic [15:0] bcd_d;
  logic colon_d;

  assign run      = (state == MODE_RUN);
  assign set_hour = (state == MODE_SET_HOUR);
  assign set_min  = (state == MODE_SET_MIN);
  // Leaving SET_MIN restarts the second so the user gets a full one.
  assign exit_set = set_min && btn_mode;
  assign phase_hi = (count < HALF);

  always_comb begin
    count_d = count + CW'(1);
    if (exit_set || count == TC)
      count_d = '0;
  end

  // tick mirrors count==TC in the same cycle, hence the look-ahead.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      tick_1hz <= 1'b0;
    end else begin
      count    <= count_d;
      tick_1hz <= (count_d == TC);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= MODE_RUN;
    else
      state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      MODE_RUN:      if (btn_mode) state_d = MODE_SET_HOUR;
      MODE_SET_HOUR: if (btn_mode) state_d = MODE_SET_MIN;
      MODE_SET_MIN:  if (btn_mode) state_d = MODE_RUN;
      MODE_BAD:      state_d = MODE_RUN;
    endcase
  end

  // A mode press in the same cycle swallows the increment.
  assign sec_inc  = run && tick_1hz;
  assign min_inc  = run ? sec_carry
                        : (set_min && btn_inc && !btn_mode);
  assign hour_inc = run ? min_carry
                        : (set_hour && btn_inc && !btn_mode);

  bcd_mod_counter #(.MAX(MIN_MAX)) u_sec (
    .clk   (clk),
    .reset (reset),
    .clr   (exit_set),
    .inc   (sec_inc),
    .value (sec_v),
    .carry (sec_carry)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (min_inc),
    .value (min_v),
    .carry (min_carry)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (hour_inc),
    .value (hour_v),
    .carry (hour_carry_unused)
  );

  always_comb begin
    bcd_d   = {hour_v, min_v};
    colon_d = 1'b1;
    unique case (1'b1)
      run:
        colon_d = phase_hi;
      set_hour:
        if (!phase_hi) bcd_d[15:8] = {BCD_BLANK, BCD_BLANK};
      set_min:
        if (!phase_hi) bcd_d[7:0] = {BCD_BLANK, BCD_BLANK};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcd      <= 16'h0000;
      colon_on <= 1'b1;
    end else begin
      bcd      <= bcd_d;
      colon_on <= colon_d;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_clock_time_controller.sv
// Directed self-checking bench for clock_time_controller (CLK_HZ=4).
// Tracks the prescaler count to predict tick, colon and blanking.
module tb_clock_time_controller;

  localparam int CLK_HZ = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic [15:0] bcd;
  logic        colon_on;
  logic [1:0]  mode;
  logic        tick_1hz;

  int checks = 0;
  int errors = 0;
  int pc = 0;
  int prev_pc = 0;
  bit bad_nib;

  clock_time_controller #(.CLK_HZ(CLK_HZ)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .bcd      (bcd),
    .colon_on (colon_on),
    .mode     (mode),
    .tick_1hz (tick_1hz)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit nib_ok(input logic [15:0] w);
    for (int i = 0; i < 4; i++)
      if (w[i*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // One clock edge; clr marks edges that zero the prescaler.
  task automatic step(input bit clr);
    prev_pc = pc;
    @(posedge clk);
    pc = clr ? 0 : ((pc == CLK_HZ - 1) ? 0 : pc + 1);
    #1;
  endtask

  task automatic press(input bit m, input bit i, input bit clr);
    btn_mode = m;
    btn_inc  = i;
    step(clr);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  initial begin
    // reset
    reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
    chk("rst_bcd", 32'(bcd), 32'h0000);
    chk("rst_colon", 32'(colon_on), 32'd1);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_tick", 32'(tick_1hz), 32'd0);

    // first second: tick once, colon 1,1,0,0
    for (int k = 0; k < 4; k++) begin
      step(1'b0);
      chk("tick1", 32'(tick_1hz), 32'(pc == 3));
      chk("colon1", 32'(colon_on), 32'(prev_pc < 2));
    end
    chk("sec01", 32'(dut.sec_v), 32'h01);
    chk("bcd_run0", 32'(bcd), 32'h0000);

    // preload 23:59 through set modes
    press(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 23; k++) press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 59; k++) press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b1);
    step(1'b0);
    chk("pre_2359", 32'(bcd), 32'h2359);
    bad_nib = 1'b0;
    for (int k = 0; k < 238; k++) begin
      step(1'b0);
      if (!nib_ok(bcd)) bad_nib = 1'b1;
    end
    chk("sec59", 32'(dut.sec_v), 32'h59);
    chk("bcd_2359", 32'(bcd), 32'h2359);
    step(1'b0);
    chk("roll_sec", 32'(dut.sec_v), 32'h00);
    chk("roll_min", 32'(dut.min_v), 32'h00);
    chk("roll_hour", 32'(dut.hour_v), 32'h00);
    step(1'b0);
    chk("roll_bcd", 32'(bcd), 32'h0000);
    chk("nibbles", 32'(bad_nib), 32'd0);

    // set minutes to 05, check blanking of minute field
    press(1'b1, 1'b0, 1'b0);
    chk("mode_sh", 32'(mode), 32'd1);
    press(1'b1, 1'b0, 1'b0);
    chk("mode_sm", 32'(mode), 32'd2);
    for (int k = 0; k < 5; k++) press(1'b0, 1'b1, 1'b0);
    chk("min05", 32'(dut.min_v), 32'h05);
    for (int k = 0; k < 4; k++) begin
      step(1'b0);
      chk("sm_lo", 32'(bcd[7:0]),
          (prev_pc < 2) ? 32'h05 : 32'hFF);
      chk("sm_hi", 32'(bcd[15:8]), 32'h00);
      chk("sm_colon", 32'(colon_on), 32'd1);
    end

    // back to RUN: sec cleared, tick in 4th cycle
    press(1'b1, 1'b0, 1'b1);
    chk("mode_run", 32'(mode), 32'd0);
    chk("sec_clr", 32'(dut.sec_v), 32'h00);
    for (int k = 1; k <= 3; k++) begin
      step(1'b0);
      chk("tick_exit", 32'(tick_1hz), 32'(k == 3));
    end
    step(1'b0);
    chk("sec_exit", 32'(dut.sec_v), 32'h01);

    // hour set: wrap 23->00, minutes untouched, hour blanks
    press(1'b1, 1'b0, 1'b0);
    chk("mode_sh2", 32'(mode), 32'd1);
    for (int k = 0; k < 3; k++) press(1'b0, 1'b1, 1'b0);
    chk("hour03", 32'(dut.hour_v), 32'h03);
    for (int k = 0; k < 21; k++) press(1'b0, 1'b1, 1'b0);
    chk("hour_wrap", 32'(dut.hour_v), 32'h00);
    chk("min_keep", 32'(dut.min_v), 32'h05);
    for (int k = 0; k < 4; k++) begin
      step(1'b0);
      chk("sh_hi", 32'(bcd[15:8]),
          (prev_pc < 2) ? 32'h00 : 32'hFF);
      chk("sh_lo", 32'(bcd[7:0]), 32'h05);
    end

    // simultaneous mode+inc: mode wins
    press(1'b0, 1'b1, 1'b0);
    chk("hour01", 32'(dut.hour_v), 32'h01);
    press(1'b1, 1'b1, 1'b0);
    chk("both_mode", 32'(mode), 32'd2);
    chk("both_hour", 32'(dut.hour_v), 32'h01);
    chk("both_min", 32'(dut.min_v), 32'h05);

    // min to 37, then reset mid-edit
    for (int k = 0; k < 32; k++) press(1'b0, 1'b1, 1'b0);
    chk("min37", 32'(dut.min_v), 32'h37);
    reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
    chk("rst2_mode", 32'(mode), 32'd0);
    chk("rst2_bcd", 32'(bcd), 32'h0000);
    chk("rst2_tick", 32'(tick_1hz), 32'd0);
    chk("rst2_min", 32'(dut.min_v), 32'h00);
    for (int k = 1; k <= 3; k++) begin
      step(1'b0);
      chk("tick_rst", 32'(tick_1hz), 32'(k == 3));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
